// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns small instruction requests (lh, sh, andi, beq, add, sub) into RV32I
//   machine words. Each accepted legal word gets an address from a running
//   counter that starts at BASE_ADDR and steps by 4. Words are held in a
//   2-entry output FIFO. Illegal kinds and bad immediates are still consumed
//   but set a sticky error flag instead of producing a word.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready request handshake
//   in_kind           0=lh 1=sh 2=andi 3=beq 4=add 5=sub 6/7=illegal
//   in_rd/rs1/rs2     register fields
//   in_imm            signed immediate (byte offset for beq)
//   clear_err         synchronous clear of err/err_cause
//   out_valid/ready   output handshake
//   out_instr         encoded word at the FIFO head
//   out_addr          address of out_instr
//   err, err_cause    sticky error, last cause (1 illegal, 2 range, 3 odd)
//   word_count        words pushed since reset, wraps at 2^16
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        clear_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic [15:0] word_count
);

  localparam logic [2:0] KIND_LH   = 3'd0;
  localparam logic [2:0] KIND_SH   = 3'd1;
  localparam logic [2:0] KIND_ANDI = 3'd2;
  localparam logic [2:0] KIND_BEQ  = 3'd3;
  localparam logic [2:0] KIND_ADD  = 3'd4;
  localparam logic [2:0] KIND_SUB  = 3'd5;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_RANGE   = 2'd2;
  localparam logic [1:0] CAUSE_ODD     = 2'd3;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int BOFF_MIN  = -4096;
  localparam int BOFF_MAX  = 4094;

  // ---------------------------------------------------------------------------
  // Encoder / legality check
  // ---------------------------------------------------------------------------
  logic        legal;
  logic [1:0]  reject_cause;
  logic [31:0] enc_word;
  logic        imm12_ok;
  logic        boff_ok;

  assign imm12_ok = ($signed(in_imm) >= IMM12_MIN) && ($signed(in_imm) <= IMM12_MAX);
  assign boff_ok  = ($signed(in_imm) >= BOFF_MIN)  && ($signed(in_imm) <= BOFF_MAX);

  // NOTE: every output of a combinational block gets a default at the top so
  // no path through the case leaves it unassigned (that would infer a latch).
  always_comb begin
    legal        = 1'b0;
    reject_cause = CAUSE_NONE;
    enc_word     = '0;
    case (in_kind)
      KIND_LH: begin
        if (imm12_ok) begin
          legal    = 1'b1;
          enc_word = {in_imm[11:0], in_rs1, 3'b001, in_rd, 7'b0000011};
        end else begin
          reject_cause = CAUSE_RANGE;
        end
      end
      KIND_SH: begin
        if (imm12_ok) begin
          legal    = 1'b1;
          enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b001, in_imm[4:0], 7'b0100011};
        end else begin
          reject_cause = CAUSE_RANGE;
        end
      end
      KIND_ANDI: begin
        if (imm12_ok) begin
          legal    = 1'b1;
          enc_word = {in_imm[11:0], in_rs1, 3'b111, in_rd, 7'b0010011};
        end else begin
          reject_cause = CAUSE_RANGE;
        end
      end
      KIND_BEQ: begin
        // An odd offset is reported as such even when it is also out of range.
        if (in_imm[0]) begin
          reject_cause = CAUSE_ODD;
        end else if (!boff_ok) begin
          reject_cause = CAUSE_RANGE;
        end else begin
          legal    = 1'b1;
          enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                      in_imm[4:1], in_imm[11], 7'b1100011};
        end
      end
      KIND_ADD: begin
        legal    = 1'b1;
        enc_word = {7'h00, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      end
      KIND_SUB: begin
        legal    = 1'b1;
        enc_word = {7'h20, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      end
      default: begin
        reject_cause = CAUSE_ILLEGAL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, wr_ptr_q;
  logic        accept, push, pop, reject;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign reject    = accept && !legal;
  assign pop       = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  logic [31:0] instr_mem_q [2];
  logic [31:0] addr_mem_q  [2];
  logic [31:0] addr_q, addr_d;

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and the outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= enc_word;
      addr_mem_q[wr_ptr_q]  <= addr_q;
    end
  end

  assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign out_addr  = out_valid ? addr_mem_q[rd_ptr_q]  : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [15:0] wc_q, wc_d;
  logic        err_q, err_d;
  logic [1:0]  cause_q, cause_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    addr_d = push ? addr_q + 32'd4 : addr_q;
    wc_d   = push ? wc_q + 16'd1   : wc_q;

    // A rejection in the same cycle as clear_err leaves the error set.
    err_d   = err_q;
    cause_d = cause_q;
    if (reject) begin
      err_d   = 1'b1;
      cause_d = reject_cause;
    end else if (clear_err) begin
      err_d   = 1'b0;
      cause_d = CAUSE_NONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      addr_q   <= BASE_ADDR;
      wc_q     <= 16'd0;
      err_q    <= 1'b0;
      cause_q  <= CAUSE_NONE;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_q ^ pop;
      wr_ptr_q <= wr_ptr_q ^ push;
      addr_q   <= addr_d;
      wc_q     <= wc_d;
      err_q    <= err_d;
      cause_q  <= cause_d;
    end
  end

  assign err        = err_q;
  assign err_cause  = cause_q;
  assign word_count = wc_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder. A reference model computes each
//   expected word from the instruction field layout with shifts and masks,
//   tracks address, word count and error state, and queues expected
//   {instr, addr} pairs; a monitor compares every handed-off word in order.
//   A second instance with BASE_ADDR = 32'hFFFF_FFFC covers address wrap.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [2:0]  in_kind = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        clear_err = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, err;
  logic [31:0] out_instr, out_addr;
  logic [1:0]  err_cause;
  logic [15:0] word_count;

  logic        in_ready2, out_valid2, err2;
  logic [31:0] out_instr2, out_addr2;
  logic [1:0]  err_cause2;
  logic [15:0] word_count2;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .clear_err(clear_err), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_cause(err_cause), .word_count(word_count)
  );

  instr_encoder #(.BASE_ADDR(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .clear_err(clear_err), .out_valid(out_valid2),
    .out_ready(out_ready), .out_instr(out_instr2), .out_addr(out_addr2),
    .err(err2), .err_cause(err_cause2), .word_count(word_count2)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [63:0] exp_q[$];
  logic [31:0] m_addr = 32'h0;
  logic [15:0] m_wc = 16'h0;
  logic        m_err = 1'b0;
  logic [1:0]  m_cause = 2'd0;
  bit          rnd_ready = 1'b0;

  function automatic void model_encode(input logic [2:0] kind, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [31:0] imm, output bit ok,
                                       output logic [1:0] cause, output logic [31:0] w);
    int s;
    s = $signed(imm);
    ok = 1'b0;
    cause = 2'd0;
    w = 32'h0;
    case (kind)
      3'd0, 3'd1, 3'd2: begin
        if (s < -2048 || s > 2047) cause = 2'd2;
        else ok = 1'b1;
        if (kind == 3'd0)
          w = 32'h03 | (32'(rd) << 7) | (32'd1 << 12) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
        else if (kind == 3'd1)
          w = 32'h23 | ((imm & 32'h1F) << 7) | (32'd1 << 12) | (32'(rs1) << 15)
              | (32'(rs2) << 20) | (((imm >> 5) & 32'h7F) << 25);
        else
          w = 32'h13 | (32'(rd) << 7) | (32'd7 << 12) | (32'(rs1) << 15) | ((imm & 32'hFFF) << 20);
      end
      3'd3: begin
        if (s % 2 != 0) cause = 2'd3;
        else if (s < -4096 || s > 4094) cause = 2'd2;
        else ok = 1'b1;
        w = 32'h63 | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hF) << 8)
            | (32'(rs1) << 15) | (32'(rs2) << 20) | (((imm >> 5) & 32'h3F) << 25)
            | (((imm >> 12) & 32'h1) << 31);
      end
      3'd4, 3'd5: begin
        ok = 1'b1;
        w = 32'h33 | (32'(rd) << 7) | (32'(rs1) << 15) | (32'(rs2) << 20)
            | ((kind == 3'd5) ? (32'h20 << 25) : 32'h0);
      end
      default: cause = 2'd1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_addr  = 32'h0;
    m_wc    = 16'h0;
    m_err   = 1'b0;
    m_cause = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    clear_err = 1'b0;
    model_reset();
    step();
    step();
    rst = 1'b0;
  endtask

  // Present one request, wait (bounded) for acceptance, update the model,
  // and compare the error/count state right after the accepting edge.
  task automatic send(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input bit clr);
    bit          ok;
    logic [1:0]  cause;
    logic [31:0] w;
    int          n;
    in_kind = kind; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      tests_run++; tests_failed++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    clear_err = clr;
    model_encode(kind, rd, rs1, rs2, imm, ok, cause, w);
    step();
    in_valid = 1'b0;
    clear_err = 1'b0;
    if (ok) begin
      exp_q.push_back({w, m_addr});
      m_addr += 32'd4;
      m_wc += 16'd1;
      if (clr) begin
        m_err = 1'b0;
        m_cause = 2'd0;
      end
    end else begin
      m_err = 1'b1;
      m_cause = cause;
    end
    tests_run++;
    if (err !== m_err || err_cause !== m_cause) begin
      tests_failed++;
      $display("FAIL err_state kind=%0d imm=%0d: err=%0b cause=%0d, required err=%0b cause=%0d",
               kind, $signed(imm), err, err_cause, m_err, m_cause);
    end
    tests_run++;
    if (word_count !== m_wc) begin
      tests_failed++;
      $display("FAIL word_count: got %0d, required %0d", word_count, m_wc);
    end
  endtask

  // Every handed-off word must be the next one the model predicted.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL mon_unexpected: got instr=%h addr=%h, required no word", out_instr, out_addr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_instr, out_addr} !== e) begin
          tests_failed++;
          $display("FAIL mon_word: got instr=%h addr=%h, required instr=%h addr=%h",
                   out_instr, out_addr, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check_drained(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    tests_run++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d words still expected, out_valid=%0b, required 0/0",
               name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err !== 1'b0 || err_cause !== 2'd0 ||
        out_instr !== 32'h0 || out_addr !== 32'h0 || word_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_state: ov=%0b ir=%0b err=%0b cause=%0d instr=%h addr=%h wc=%0d, required 0 1 0 0 0 0 0",
               out_valid, in_ready, err, err_cause, out_instr, out_addr, word_count);
    end
  endtask

  task automatic test_directed();
    do_reset();
    out_ready = 1'b1;
    send(3'd0, 5'd5, 5'd2, 5'd0, -32'sd4, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFC11283 || out_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL lh_latency: ov=%0b instr=%h addr=%h, required 1 FFC11283 00000000",
               out_valid, out_instr, out_addr);
    end
    step();
    do_reset();
    out_ready = 1'b1;
    send(3'd1, 5'd0, 5'd2, 5'd6, 32'd8, 1'b0);
    tests_run++;
    if (out_instr !== 32'h00611423 || out_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL sh_word: instr=%h addr=%h, required 00611423 00000000", out_instr, out_addr);
    end
    send(3'd3, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0);
    tests_run++;
    if (out_instr !== 32'hFE208CE3 || out_addr !== 32'h4) begin
      tests_failed++;
      $display("FAIL beq_word: instr=%h addr=%h, required FE208CE3 00000004", out_instr, out_addr);
    end
    check_drained("directed");
  endtask

  task automatic test_errors();
    logic [2:0]  kinds [12] = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd0, 3'd1, 3'd1,
                                3'd3, 3'd3, 3'd3, 3'd3, 3'd6};
    logic [31:0] imms  [12] = '{32'd4094, -32'sd4096, 32'd2047, -32'sd2048, 32'd2048,
                                -32'sd2049, 32'd1234, 32'd4096, -32'sd4098, 32'd5001,
                                32'd2, 32'd0};
    do_reset();
    out_ready = 1'b1;
    send(3'd3, 5'd0, 5'd1, 5'd2, 32'd5, 1'b0);
    tests_run++;
    if (err_cause !== 2'd3 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL beq_odd: cause=%0d ov=%0b, required 3 0", err_cause, out_valid);
    end
    send(3'd2, 5'd1, 5'd1, 5'd0, 32'd4096, 1'b0);
    tests_run++;
    if (err !== 1'b1 || err_cause !== 2'd2 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL andi_range: err=%0b cause=%0d ov=%0b, required 1 2 0", err, err_cause, out_valid);
    end
    // Clear coincident with a rejection: rejection wins.
    send(3'd7, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);
    send(3'd4, 5'd1, 5'd2, 5'd3, 32'hDEAD_BEEF, 1'b0);
    tests_run++;
    if (out_addr !== 32'h0 || word_count !== 16'd1 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL after_reject: addr=%h wc=%0d err=%0b, required 00000000 1 1",
               out_addr, word_count, err);
    end
    send(3'd5, 5'd4, 5'd5, 5'd6, 32'd0, 1'b1);
    for (int i = 0; i < 12; i++)
      send(kinds[i], 5'(i), 5'(i + 3), 5'(i + 7), imms[i], 1'b0);
    check_drained("errors");
  endtask

  task automatic test_back_to_back();
    logic [31:0] hold_instr, hold_addr;
    do_reset();
    out_ready = 1'b0;
    send(3'd4, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    send(3'd2, 5'd7, 5'd8, 5'd0, 32'd100, 1'b0);
    tests_run++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_ready: in_ready=%0b ov=%0b, required 0 1", in_ready, out_valid);
    end
    hold_instr = out_instr;
    hold_addr  = out_addr;
    in_kind = 3'd5; in_rd = 5'd9; in_rs1 = 5'd10; in_rs2 = 5'd11;
    in_valid = 1'b1;
    step();
    step();
    tests_run++;
    if (in_ready !== 1'b0 || out_instr !== hold_instr || out_addr !== hold_addr ||
        out_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL stall_hold: ir=%0b instr=%h addr=%h, required 0 %h 00000000",
               in_ready, out_instr, out_addr, hold_instr);
    end
    out_ready = 1'b1;
    send(3'd5, 5'd9, 5'd10, 5'd11, 32'd0, 1'b0);
    check_drained("b2b");
  endtask

  task automatic test_midstream_reset();
    do_reset();
    out_ready = 1'b0;
    send(3'd4, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
    send(3'd4, 5'd2, 5'd2, 5'd2, 32'd0, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || word_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: ov=%0b ir=%0b wc=%0d, required 0 1 0", out_valid, in_ready, word_count);
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    send(3'd2, 5'd3, 5'd4, 5'd0, 32'd15, 1'b0);
    tests_run++;
    if (out_addr !== 32'h0 || word_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL post_reset_word: addr=%h wc=%0d, required 00000000 1", out_addr, word_count);
    end
    check_drained("midrst");
  endtask

  task automatic test_base_wrap();
    do_reset();
    out_ready = 1'b1;
    send(3'd4, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    tests_run++;
    if (out_valid2 !== 1'b1 || out_addr2 !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL wrap_first: ov=%0b addr=%h, required 1 FFFFFFFC", out_valid2, out_addr2);
    end
    send(3'd5, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    tests_run++;
    if (out_valid2 !== 1'b1 || out_addr2 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_second: ov=%0b addr=%h, required 1 00000000", out_valid2, out_addr2);
    end
    check_drained("wrap");
  endtask

  task automatic test_random();
    int v;
    int edges [8] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098};
    do_reset();
    rnd_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: v = int'($urandom_range(0, 128)) - 64;
        1: v = int'($urandom);
        2: v = edges[$urandom_range(0, 7)];
        default: v = (int'($urandom_range(0, 4200)) - 2100) * 2;
      endcase
      send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
           32'(v), ($urandom_range(0, 7) == 0));
    end
    rnd_ready = 1'b0;
    check_drained("random");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_back_to_back();
    test_midstream_reset();
    test_base_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: address assigned to the first emitted word after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  request carries an instruction to encode.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_kind  input  3  0=lh, 1=sh, 2=andi, 3=beq, 4=add, 5=sub, 6/7=illegal.
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_imm  input  32  signed immediate, byte offset for beq.
REQ-009 clear_err  input  1  synchronous clear of err and err_cause.
REQ-010 out_valid  output  1  out_instr/out_addr hold a valid encoded word.
REQ-011 out_ready  input  1  consumer takes the word this cycle.
REQ-012 out_instr  output  32  encoded RV32I word.
REQ-013 out_addr  output  32  address assigned to out_instr.
REQ-014 err  output  1  sticky, set on any rejected request.
REQ-015 err_cause  output  2  last rejection: 1=illegal kind, 2=immediate out of range, 3=branch offset odd.
REQ-016 word_count  output  16  number of words accepted into the buffer since reset, wraps at 2^16.

Function
REQ-017 Handshake: request accepted when in_valid && in_ready; word handed off when out_valid && out_ready.
REQ-018 Output buffer: 2-entry FIFO of {instr, addr}; in_ready = (occupancy < 2); no combinational path from out_ready to in_ready.
REQ-019 Latency: a legal request accepted in cycle N appears on out_valid in cycle N+1 when the FIFO is empty.
REQ-020 Encoding lh: {imm[11:0], rs1, 3'b001, rd, 7'b0000011}.
REQ-021 Encoding sh: {imm[11:5], rs2, rs1, 3'b001, imm[4:0], 7'b0100011}.
REQ-022 Encoding andi: {imm[11:0], rs1, 3'b111, rd, 7'b0010011}.
REQ-023 Encoding beq: {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011}.
REQ-024 Encoding add/sub: {funct7, rs2, rs1, 3'b000, rd, 7'b0110011}, funct7 = 7'h00 (add) / 7'h20 (sub).
REQ-025 Range: lh/sh/andi require -2048 <= in_imm <= 2047; beq requires -4096 <= in_imm <= 4094 and in_imm[0]=0; add/sub ignore in_imm.
REQ-026 Rejected request (illegal kind, range, odd offset): still handshaken (consumed), nothing pushed, address and word_count unchanged, err=1, err_cause updated; odd check has priority over range check.
REQ-027 Address counter: starts at BASE_ADDR, each pushed word takes current value, then counter += 4; wraps modulo 2^32.
REQ-028 Push and pop in same cycle with occupancy 1: occupancy stays 1, order preserved.
REQ-029 out_instr/out_addr stable while out_valid && !out_ready.
REQ-030 clear_err coincident with a rejection: rejection wins, err stays 1 with new cause.

Reset
REQ-031 On rst: FIFO emptied, out_valid=0, in_ready=1, address counter=BASE_ADDR, word_count=0, err=0, err_cause=0, out_instr=0, out_addr=0.
REQ-032 rst asserted mid-stream discards all buffered words; first word after release gets BASE_ADDR.

Verification
REQ-033 lh rd=5 rs1=2 imm=-4, out_ready=1 -> next cycle out_valid=1, out_instr=32'hFFC11283, out_addr=0.
REQ-034 sh rs2=6 rs1=2 imm=8 then beq rs1=1 rs2=2 imm=-8 -> 32'h00611423 at addr 0, 32'hFE208CE3 at addr 4.
REQ-035 beq imm=5, then andi imm=4096 -> no output, err=1, err_cause 3 then 2, next legal word still at addr 0, word_count=1.
REQ-036 out_ready=0, three back-to-back legal requests -> in_ready low after second accept, third held; release out_ready -> words at addr 0,4,8 in order.
REQ-037 rst pulsed with 2 words buffered -> out_valid=0 immediately, next word at BASE_ADDR, word_count restarts at 1.
REQ-038 BASE_ADDR=32'hFFFF_FFFC, two words -> addresses FFFF_FFFC then 0000_0000.
